// File: rtl/xspi_pkg.sv
// Shared opcodes, lane modes, phase bit counts and state encoding for the
// xSPI flash-emulation command path.
package xspi_pkg;

    localparam logic [7:0] OPC_READ        = 8'h03;
    localparam logic [7:0] OPC_FAST_READ   = 8'h0B;
    localparam logic [7:0] OPC_QUAD_READ   = 8'h6B;
    localparam logic [7:0] OPC_PAGE_PROG   = 8'h02;
    localparam logic [7:0] OPC_READ_STATUS = 8'h05;
    localparam logic [7:0] OPC_READ_ID     = 8'h9F;

    localparam logic [1:0] XSPI_X1 = 2'b00;
    localparam logic [1:0] XSPI_X2 = 2'b01;
    localparam logic [1:0] XSPI_X4 = 2'b10;

    localparam int BC_BYTE = 8;
    localparam int BC_ADDR = 24;
    localparam int BC_WORD = 32;

    typedef enum logic [2:0] {
        ST_OPC,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_REG,
        ST_DRAIN
    } xspi_state_e;

endpackage

// File: rtl/xspi_sync.sv
// Two-flop synchronizer; with RISE_EDGE set, q_o is instead a registered
// one-cycle pulse on the synchronized rising edge.
module xspi_sync #(
    parameter bit RISE_EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    if (RISE_EDGE) begin : g_rise
        logic prev_q;
        logic rise_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                prev_q <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                prev_q <= sync_q[1];
                rise_q <= sync_q[1] & ~prev_q;
            end
        end

        assign q_o = rise_q;
    end else begin : g_level
        assign q_o = sync_q[1];
    end

endmodule

// File: rtl/xspi_cmd_seq.sv
// xSPI slave command sequencer: decodes the opcode, programs each PHY phase
// and turns address/data phases into word requests on the memory port.
//
// state    | meaning
// ST_OPC   | receiving the opcode byte (idle)
// ST_ADDR  | receiving the 24-bit address
// ST_DUMMY | 8 dummy cycles while the first read word is prefetched
// ST_RDATA | driving read words, prefetching the next on every word
// ST_WDATA | receiving program words and writing them out
// ST_REG   | driving a status/ID register value
// ST_DRAIN | ignoring the bus until chip enable drops
module xspi_cmd_seq
    import xspi_pkg::*;
#(
    parameter int WORD_SIZE        = 32,
    parameter int CYCLE_COUNT_BITS = 6,
    parameter int ADDR_BITS        = 24
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        sce_i,
    input  logic                        phy_txndone_i,
    input  logic [WORD_SIZE-1:0]        phy_txndata_i,
    output logic [CYCLE_COUNT_BITS-1:0] phy_txnbc_o,
    output logic [1:0]                  phy_txnmode_o,
    output logic                        phy_txndir_o,
    output logic [WORD_SIZE-1:0]        phy_txndata_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [ADDR_BITS-1:0]        mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    input  logic                        mem_ack_i,
    input  logic [31:0]                 mem_rdata_i,
    input  logic [7:0]                  status_i,
    input  logic [23:0]                 id_i,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam logic [CYCLE_COUNT_BITS-1:0] BC8  = CYCLE_COUNT_BITS'(BC_BYTE);
    localparam logic [CYCLE_COUNT_BITS-1:0] BC24 = CYCLE_COUNT_BITS'(BC_ADDR);
    localparam logic [CYCLE_COUNT_BITS-1:0] BC32 = CYCLE_COUNT_BITS'(BC_WORD);

    logic sce_s;
    logic ev;

    xspi_sync #(.RISE_EDGE(1'b0)) u_sce_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sce_i),
        .q_o   (sce_s)
    );

    xspi_sync #(.RISE_EDGE(1'b1)) u_done_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (phy_txndone_i),
        .q_o   (ev)
    );

    xspi_state_e          state_q;
    logic [7:0]           opc_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_SIZE-1:0] rd_buf_q;
    logic                 rd_valid_q;
    logic                 discard_q;

    logic [ADDR_BITS-1:0] addr_next;
    logic [ADDR_BITS-1:0] addr_rx;
    logic                 port_busy;
    logic                 prog_rdata;

    assign addr_next = addr_q + ADDR_BITS'(4);
    assign addr_rx   = {phy_txndata_i[ADDR_BITS-1:2], 2'b00};
    assign port_busy = mem_req_o & ~mem_ack_i;
    // Every event that opens a read-data transaction hands over the prefetch buffer.
    assign prog_rdata = sce_s & ev &
                        ((state_q == ST_ADDR && opc_q == OPC_READ) ||
                         state_q == ST_DUMMY || state_q == ST_RDATA);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_OPC;
            opc_q         <= 8'h00;
            addr_q        <= '0;
            rd_buf_q      <= '0;
            rd_valid_q    <= 1'b0;
            discard_q     <= 1'b0;
            phy_txnbc_o   <= BC8;
            phy_txnmode_o <= XSPI_X1;
            phy_txndir_o  <= 1'b0;
            phy_txndata_o <= '0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            busy_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            if (mem_ack_i) begin
                mem_req_o <= 1'b0;
                discard_q <= 1'b0;
            end

            if (!sce_s) begin
                state_q       <= ST_OPC;
                phy_txnbc_o   <= BC8;
                phy_txnmode_o <= XSPI_X1;
                phy_txndir_o  <= 1'b0;
                phy_txndata_o <= '0;
                busy_o        <= 1'b0;
                rd_valid_q    <= 1'b0;
                if (port_busy) begin
                    discard_q <= 1'b1;
                end
            end else if (ev) begin
                unique case (state_q)
                    ST_OPC: begin
                        opc_q      <= phy_txndata_i[7:0];
                        busy_o     <= 1'b1;
                        rd_valid_q <= 1'b0;
                        case (phy_txndata_i[7:0])
                            OPC_READ, OPC_FAST_READ, OPC_QUAD_READ, OPC_PAGE_PROG: begin
                                state_q     <= ST_ADDR;
                                phy_txnbc_o <= BC24;
                            end
                            OPC_READ_STATUS: begin
                                state_q       <= ST_REG;
                                phy_txndir_o  <= 1'b1;
                                phy_txndata_o <= WORD_SIZE'({status_i, 24'h0});
                            end
                            OPC_READ_ID: begin
                                state_q       <= ST_REG;
                                phy_txnbc_o   <= BC24;
                                phy_txndir_o  <= 1'b1;
                                phy_txndata_o <= WORD_SIZE'({id_i, 8'h0});
                            end
                            default: begin
                                state_q <= ST_DRAIN;
                                err_o   <= 1'b1;
                            end
                        endcase
                    end
                    ST_ADDR: begin
                        addr_q <= addr_rx;
                        if (opc_q == OPC_PAGE_PROG) begin
                            state_q     <= ST_WDATA;
                            phy_txnbc_o <= BC32;
                        end else begin
                            if (port_busy) begin
                                err_o <= 1'b1;
                            end else begin
                                mem_req_o  <= 1'b1;
                                mem_we_o   <= 1'b0;
                                mem_addr_o <= addr_rx;
                            end
                            if (opc_q == OPC_READ) begin
                                state_q <= ST_RDATA;
                            end else begin
                                state_q     <= ST_DUMMY;
                                phy_txnbc_o <= BC8;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        state_q <= ST_RDATA;
                    end
                    ST_RDATA: begin
                        addr_q <= addr_next;
                        if (port_busy) begin
                            err_o <= 1'b1;
                        end else begin
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= addr_next;
                        end
                    end
                    ST_WDATA: begin
                        // A word arriving while the previous write is still pending is dropped.
                        if (port_busy) begin
                            err_o <= 1'b1;
                        end else begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= addr_q;
                            mem_wdata_o <= 32'(phy_txndata_i);
                            addr_q      <= addr_next;
                        end
                    end
                    ST_REG: begin
                        state_q       <= ST_DRAIN;
                        phy_txnbc_o   <= BC8;
                        phy_txndir_o  <= 1'b0;
                        phy_txndata_o <= '0;
                    end
                    ST_DRAIN: begin
                        state_q <= ST_DRAIN;
                    end
                    default: begin
                        state_q <= ST_OPC;
                    end
                endcase

                if (prog_rdata) begin
                    phy_txnbc_o   <= BC32;
                    phy_txnmode_o <= (opc_q == OPC_QUAD_READ) ? XSPI_X4 : XSPI_X1;
                    phy_txndir_o  <= 1'b1;
                    phy_txndata_o <= rd_valid_q ? rd_buf_q : '1;
                    rd_valid_q    <= 1'b0;
                    if (!rd_valid_q) begin
                        err_o <= 1'b1;
                    end
                end
            end

            // Late read data is kept for the next word; data of an aborted command is not.
            if (mem_ack_i && !mem_we_o && !discard_q && sce_s) begin
                rd_buf_q   <= WORD_SIZE'(mem_rdata_i);
                rd_valid_q <= 1'b1;
            end
        end
    end

endmodule
